// File: rtl/mod_keypad_scan_if.sv
// Key delivery handshake between the keypad scanner and its consumer.
// The scanner drives the head key code and valid; the consumer returns ack.
interface mod_keypad_scan_if;
  logic [3:0] outKeyCode;
  logic       outKeyValid;
  logic       inKeyAck;

  modport master (output outKeyCode, output outKeyValid, input inKeyAck);
  modport slave  (input outKeyCode, input outKeyValid, output inKeyAck);
endinterface

// File: rtl/mod_keypad_scan.sv
// 4x4 keypad scanner: row sync, column scan, frame debounce, 4-entry key FIFO.
// Optional ghost-key rejection is enabled by defining MOD_KEYSCAN_GHOSTREJ_EN.
module mod_keypad_scan #(
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inStrobe1kHz,
  input  logic [3:0]               inRowBit,
  output logic [3:0]               outColBit,
  mod_keypad_scan_if.master        keyBus,
  output logic [15:0]              outKeyHeld,
  output logic                     outKeyOverrun
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE_CNT);

  logic [3:0]  rowMeta, rowSync;
  logic [1:0]  col;
  logic [15:0] frame, prevFrame, held, pending;
  logic        frameDone;
  logic [3:0]  stableCnt;
  logic [3:0]  fifoMem [4];
  logic [1:0]  wrPtr, rdPtr;
  logic [2:0]  fifoCnt;
  logic        keyValid;

  logic [3:0]  cntNext;
  logic        accept, ghost;
  logic [15:0] newBits, clearMask;
  logic [3:0]  pushCode;
  logic        pushReq, popReq;

  always_comb begin
    cntNext = stableCnt;
    accept  = 1'b0;
    newBits = '0;
    ghost   = 1'b0;
`ifdef MOD_KEYSCAN_GHOSTREJ_EN
    begin
      logic [4:0] bitCount;
      bitCount = '0;
      for (int i = 0; i < 16; i++) bitCount = bitCount + 5'(frame[i]);
      ghost = (bitCount > 5'd2);
    end
`endif
    if (frameDone) begin
      if (ghost || frame != prevFrame) cntNext = '0;
      else if (stableCnt == DEB)       cntNext = DEB;
      else                             cntNext = stableCnt + 4'd1;
      accept = !ghost && (cntNext == DEB) && (frame != held);
      if (accept) newBits = frame & ~held;
    end
  end

  // Lowest-index pending key wins; the loop runs high to low so the last hit sticks.
  always_comb begin
    pushCode = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) pushCode = 4'(i);
    end
    popReq    = keyBus.inKeyAck && keyValid && (fifoCnt != 3'd0);
    pushReq   = (pending != '0) && ((fifoCnt != 3'd4) || popReq);
    clearMask = pushReq ? (16'b1 << pushCode) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rowMeta       <= '0;
      rowSync       <= '0;
      col           <= '0;
      outColBit     <= 4'b1110;
      frame         <= '0;
      prevFrame     <= '0;
      held          <= '0;
      pending       <= '0;
      frameDone     <= 1'b0;
      stableCnt     <= '0;
      wrPtr         <= '0;
      rdPtr         <= '0;
      fifoCnt       <= '0;
      keyValid      <= 1'b0;
      outKeyOverrun <= 1'b0;
      for (int i = 0; i < 4; i++) fifoMem[i] <= '0;
    end else begin
      rowMeta   <= inRowBit;
      rowSync   <= rowMeta;
      frameDone <= inStrobe1kHz && (col == 2'd3);
      if (inStrobe1kHz) begin
        // Frame bit index is row*4+col so that it matches the key code.
        for (int r = 0; r < 4; r++) frame[r*4 + int'(col)] <= ~rowSync[r];
        col       <= col + 2'd1;
        outColBit <= ~(4'b0001 << (col + 2'd1));
      end
      if (frameDone) begin
        stableCnt <= cntNext;
        prevFrame <= frame;
      end
      if (accept) held <= frame;
      pending <= (pending & ~clearMask) | newBits;
      if ((newBits & pending & ~clearMask) != '0) outKeyOverrun <= 1'b1;
      if (pushReq) begin
        fifoMem[wrPtr] <= pushCode;
        wrPtr          <= wrPtr + 2'd1;
      end
      if (popReq) rdPtr <= rdPtr + 2'd1;
      fifoCnt  <= fifoCnt + {2'b0, pushReq} - {2'b0, popReq};
      keyValid <= (fifoCnt != 3'd0);
    end
  end

  assign keyBus.outKeyCode  = fifoMem[rdPtr];
  assign keyBus.outKeyValid = keyValid;
  assign outKeyHeld         = held;

endmodule
